mem_lsu: RTL and testbench

Memory-access stage of the single-cycle RISC-V core, between the execute datapath and the write-back stage. It takes one instruction's ALU result, register target and load/store control from execute. It runs loads and stores over a req/ack data bus, with byte-lane steering and sign/zero extension, and stalls upstream while a bus access is in flight. Its registered outputs (MemWriteNum, MemWriteReg, MemWriteData) drive write-back directly.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/mem_align.sv | 71 +++++++
 rtl/mem_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the memory-access stage (mem_lsu).
//   - RV32I load/store funct3 encodings
//   - FSM state type (IDLE/BUSY)
//   - bus watchdog counter width
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane logic for mem_lsu.
//   is_load/is_store  access kind
//   funct3            RV32I size/sign encoding
//   addr_lo           effective address bits [1:0]
//   st_data           rs2 value; st_be/st_wdata are the lane-steered bus view
//   rdata             bus read word; ld_data is the extracted, extended value
//   misalign          access cannot be issued (bad alignment or undefined funct3)
module mem_align
  import lsu_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    misalign = 1'b0;
    if (is_load || is_store) begin
      case (funct3)
        LB:      misalign = 1'b0;
        LH:      misalign = addr_lo[0];
        LW:      misalign = (addr_lo != 2'b00);
        // Unsigned variants exist only for loads; for stores they are undefined.
        LBU:     misalign = is_store;
        LHU:     misalign = is_store || addr_lo[0];
        default: misalign = 1'b1;
      endcase
    end
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << addr_lo;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Halfword lane uses addr_lo[1] only; odd halfword addresses never reach the bus.
  assign ld_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign ld_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3)
      LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
      LH:      ld_data = {{16{ld_half[15]}}, ld_half};
      LBU:     ld_data = {24'h0, ld_byte};
      LHU:     ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage of the single-cycle RV32I core.
//   Ex*          instruction from execute (held by upstream while MemStall=1)
//   MemWrite*    registered result to write-back
//   MemMisalign  one-cycle pulse for a misaligned / undefined access
//   MemBusErr    one-cycle pulse on watchdog abort
//   DBus*        req/ack data bus; request held stable until ack
// Optional feature: define LSU_TIMEOUT_EN to enable the bus watchdog
// (limit TIMEOUT_CYCLES); without it BUSY waits forever and MemBusErr stays 0.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ExValid,
  input  logic        ExMemRead,
  input  logic        ExMemWrite,
  input  logic [2:0]  ExFunct3,
  input  logic [31:0] ExAluResult,
  input  logic [31:0] ExStoreData,
  input  logic [4:0]  ExWriteNum,
  input  logic        ExWriteReg,
  output logic        MemStall,
  output logic [4:0]  MemWriteNum,
  output logic        MemWriteReg,
  output logic [31:0] MemWriteData,
  output logic        MemMisalign,
  output logic        MemBusErr,
  output logic        DBusReq,
  output logic        DBusWe,
  output logic [31:0] DBusAddr,
  output logic [3:0]  DBusBe,
  output logic [31:0] DBusWdata,
  input  logic [31:0] DBusRdata,
  input  logic        DBusAck
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] sdata_q, sdata_d;
  logic [4:0]  wnum_q, wnum_d;
  logic        wreg_q, wreg_d;
  logic        store_q, store_d;

  logic [4:0]  out_num_q, out_num_d;
  logic        out_reg_q, out_reg_d;
  logic [31:0] out_data_q, out_data_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        busy, stall, timeout_hit;
  logic        al_load, al_store, al_misalign;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld_data;

  assign busy = (state_q == BUSY);

  // One aligner serves both phases: Ex* for misalign checks in IDLE,
  // latched request for lane steering / load extraction in BUSY.
  assign al_load   = busy ? !store_q : ExMemRead;
  assign al_store  = busy ? store_q  : ExMemWrite;
  assign al_funct3 = busy ? funct3_q : ExFunct3;
  assign al_addr   = busy ? addr_q[1:0] : ExAluResult[1:0];

  mem_align u_align (
    .is_load  (al_load),
    .is_store (al_store),
    .funct3   (al_funct3),
    .addr_lo  (al_addr),
    .st_data  (sdata_q),
    .rdata    (DBusRdata),
    .st_be    (al_be),
    .st_wdata (al_wdata),
    .ld_data  (al_ld_data),
    .misalign (al_misalign)
  );

`ifdef LSU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero in IDLE, so it is clear on every BUSY entry.
  always_comb begin
    cnt_d = cnt_q;
    if (!busy)         cnt_d = '0;
    else if (!DBusAck) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout_hit = busy && !DBusAck && (cnt_q == CNT_LIMIT);
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    sdata_d    = sdata_q;
    wnum_d     = wnum_q;
    wreg_d     = wreg_q;
    store_d    = store_q;
    out_num_d  = out_num_q;
    out_data_d = out_data_q;
    out_reg_d  = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ExValid) begin
          if (ExMemRead || ExMemWrite) begin
            if (al_misalign) begin
              misalign_d = 1'b1;
            end else begin
              stall    = 1'b1;
              addr_d   = ExAluResult;
              funct3_d = ExFunct3;
              sdata_d  = ExStoreData;
              wnum_d   = ExWriteNum;
              wreg_d   = ExWriteReg;
              store_d  = ExMemWrite;
              state_d  = BUSY;
            end
          end else begin
            out_data_d = ExAluResult;
            out_num_d  = ExWriteNum;
            out_reg_d  = ExWriteReg && (ExWriteNum != 5'd0);
          end
        end
      end
      BUSY: begin
        if (DBusAck) begin
          if (!store_q) begin
            out_data_d = al_ld_data;
            out_num_d  = wnum_q;
            out_reg_d  = wreg_q && (wnum_q != 5'd0);
          end
          state_d = IDLE;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      sdata_q    <= '0;
      wnum_q     <= '0;
      wreg_q     <= 1'b0;
      store_q    <= 1'b0;
      out_num_q  <= '0;
      out_reg_q  <= 1'b0;
      out_data_q <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      sdata_q    <= sdata_d;
      wnum_q     <= wnum_d;
      wreg_q     <= wreg_d;
      store_q    <= store_d;
      out_num_q  <= out_num_d;
      out_reg_q  <= out_reg_d;
      out_data_q <= out_data_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign MemStall     = stall;
  assign MemWriteNum  = out_num_q;
  assign MemWriteReg  = out_reg_q;
  assign MemWriteData = out_data_q;
  assign MemMisalign  = misalign_q;
  assign MemBusErr    = bus_err_q;

  // Bus view comes only from latched state, so it cannot move while waiting for ack.
  assign DBusReq   = busy;
  assign DBusWe    = busy && store_q;
  assign DBusAddr  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
  assign DBusBe    = (busy && store_q) ? al_be : 4'b0000;
  assign DBusWdata = (busy && store_q) ? al_wdata : 32'h0;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ExValid, ExMemRead, ExMemWrite, ExWriteReg;
  logic [2:0]  ExFunct3;
  logic [31:0] ExAluResult, ExStoreData;
  logic [4:0]  ExWriteNum;
  logic        MemStall, MemWriteReg, MemMisalign, MemBusErr;
  logic [4:0]  MemWriteNum;
  logic [31:0] MemWriteData;
  logic        DBusReq, DBusWe, DBusAck;
  logic [31:0] DBusAddr, DBusWdata, DBusRdata;
  logic [3:0]  DBusBe;

  int checks = 0;
  int errors = 0;

  int          n_stall, n_req;
  bit          stable;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ExValid(ExValid), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
    .ExFunct3(ExFunct3), .ExAluResult(ExAluResult), .ExStoreData(ExStoreData),
    .ExWriteNum(ExWriteNum), .ExWriteReg(ExWriteReg),
    .MemStall(MemStall), .MemWriteNum(MemWriteNum), .MemWriteReg(MemWriteReg),
    .MemWriteData(MemWriteData), .MemMisalign(MemMisalign), .MemBusErr(MemBusErr),
    .DBusReq(DBusReq), .DBusWe(DBusWe), .DBusAddr(DBusAddr), .DBusBe(DBusBe),
    .DBusWdata(DBusWdata), .DBusRdata(DBusRdata), .DBusAck(DBusAck)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] num, input logic wen);
    ExValid = 1'b1; ExMemRead = rd; ExMemWrite = wr; ExFunct3 = f3;
    ExAluResult = a; ExStoreData = sd; ExWriteNum = num; ExWriteReg = wen;
  endtask

  task automatic clr_ex();
    ExValid = 1'b0; ExMemRead = 1'b0; ExMemWrite = 1'b0;
  endtask

  // Drives one accepted access: acceptance cycle, `waits` un-acked BUSY cycles,
  // then the ack cycle. Ends at the negedge of the cycle where the result shows.
  task automatic run_access(input int waits, input logic [31:0] rdata);
    n_stall = 0; n_req = 0; stable = 1'b1;
    for (int c = 0; c <= waits + 1; c++) begin
      DBusAck   = (c == waits + 1);
      DBusRdata = (c == waits + 1) ? rdata : 32'h5A5A_5A5A;
      @(negedge clk);
      if (MemStall) n_stall++;
      if (DBusReq)  n_req++;
      if (c == 1) begin
        cap_addr = DBusAddr; cap_be = DBusBe; cap_wdata = DBusWdata; cap_we = DBusWe;
      end else if (c > 1 && {DBusAddr, DBusBe, DBusWdata, DBusWe} !== {cap_addr, cap_be, cap_wdata, cap_we}) begin
        stable = 1'b0;
      end
      tick();
    end
    DBusAck = 1'b0;
    clr_ex();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (MemWriteData !== 32'h0) begin errors++; $display("FAIL reset_data: got %h exp %h", MemWriteData, 32'h0); end
    checks++; if (MemWriteReg !== 1'b0) begin errors++; $display("FAIL reset_reg: got %b exp 0", MemWriteReg); end
    checks++; if (MemWriteNum !== 5'd0) begin errors++; $display("FAIL reset_num: got %0d exp 0", MemWriteNum); end
    checks++; if ({MemStall, DBusReq, MemMisalign, MemBusErr} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {MemStall, DBusReq, MemMisalign, MemBusErr}); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_nonmem();
    tick();
    set_ex(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
    @(negedge clk);
    checks++; if (MemStall !== 1'b0) begin errors++; $display("FAIL nonmem_stall: got %b exp 0", MemStall); end
    tick();
    clr_ex();
    @(negedge clk);
    checks++; if (MemWriteData !== 32'h1234_5678) begin errors++; $display("FAIL nonmem_data: got %h exp %h", MemWriteData, 32'h1234_5678); end
    checks++; if (MemWriteReg !== 1'b1) begin errors++; $display("FAIL nonmem_reg: got %b exp 1", MemWriteReg); end
    checks++; if (MemWriteNum !== 5'd5) begin errors++; $display("FAIL nonmem_num: got %0d exp 5", MemWriteNum); end
    tick();
    @(negedge clk);
    checks++; if (MemWriteReg !== 1'b0) begin errors++; $display("FAIL novalid_reg: got %b exp 0", MemWriteReg); end
    checks++; if (MemWriteData !== 32'h1234_5678) begin errors++; $display("FAIL novalid_hold: got %h exp %h", MemWriteData, 32'h1234_5678); end
    tick();
    set_ex(1'b0, 1'b0, 3'b000, 32'h0BAD_0000, 32'h0, 5'd0, 1'b1);
    tick();
    clr_ex();
    @(negedge clk);
    checks++; if (MemWriteReg !== 1'b0) begin errors++; $display("FAIL nonmem_x0_reg: got %b exp 0", MemWriteReg); end
    checks++; if (MemWriteData !== 32'h0BAD_0000) begin errors++; $display("FAIL nonmem_x0_data: got %h exp %h", MemWriteData, 32'h0BAD_0000); end
  endtask

  task automatic test_loads();
    tick();
    set_ex(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
    run_access(3, 32'h80AA_BBCC);
    checks++; if (n_stall !== 4) begin errors++; $display("FAIL lb_stall_cycles: got %0d exp 4", n_stall); end
    checks++; if (n_req !== 4) begin errors++; $display("FAIL lb_req_cycles: got %0d exp 4", n_req); end
    checks++; if (cap_addr !== 32'h0000_0100) begin errors++; $display("FAIL lb_addr: got %h exp %h", cap_addr, 32'h100); end
    checks++; if ({cap_be, cap_we} !== 5'b0000_0) begin errors++; $display("FAIL lb_be_we: got %b exp 00000", {cap_be, cap_we}); end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL lb_bus_stable: got %b exp 1", stable); end
    checks++; if (MemWriteData !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h exp %h", MemWriteData, 32'hFFFF_FF80); end
    checks++; if ({MemWriteReg, MemWriteNum} !== {1'b1, 5'd7}) begin errors++; $display("FAIL lb_wb: got %b/%0d exp 1/7", MemWriteReg, MemWriteNum); end

    tick();
    set_ex(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd8, 1'b1);
    run_access(3, 32'h80AA_BBCC);
    checks++; if (MemWriteData !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h exp %h", MemWriteData, 32'h80); end

    // fastest case: ack in the first BUSY cycle
    tick();
    set_ex(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd9, 1'b1);
    run_access(0, 32'h8001_1234);
    checks++; if (n_stall !== 1) begin errors++; $display("FAIL lh_stall_cycles: got %0d exp 1", n_stall); end
    checks++; if (MemWriteData !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data: got %h exp %h", MemWriteData, 32'hFFFF_8001); end

    tick();
    set_ex(1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0, 5'd9, 1'b1);
    run_access(0, 32'h8001_9234);
    checks++; if (MemWriteData !== 32'h0000_9234) begin errors++; $display("FAIL lhu_data: got %h exp %h", MemWriteData, 32'h9234); end

    tick();
    set_ex(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 5'd3, 1'b1);
    run_access(1, 32'hDEAD_BEEF);
    checks++; if (MemWriteData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h exp %h", MemWriteData, 32'hDEAD_BEEF); end
    checks++; if (cap_addr !== 32'h0000_0104) begin errors++; $display("FAIL lw_addr: got %h exp %h", cap_addr, 32'h104); end
  endtask

  task automatic test_stores();
    tick();
    set_ex(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd4, 1'b1);
    run_access(1, 32'h0);
    checks++; if (cap_addr !== 32'h0000_0200) begin errors++; $display("FAIL sh_addr: got %h exp %h", cap_addr, 32'h200); end
    checks++; if (cap_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b exp 1100", cap_be); end
    checks++; if (cap_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h exp %h", cap_wdata, 32'hBEEF_BEEF); end
    checks++; if (cap_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b exp 1", cap_we); end
    checks++; if (MemWriteReg !== 1'b0) begin errors++; $display("FAIL sh_reg: got %b exp 0", MemWriteReg); end

    tick();
    set_ex(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5, 5'd4, 1'b1);
    run_access(0, 32'h0);
    checks++; if ({cap_be, cap_wdata} !== {4'b0010, 32'hA5A5_A5A5}) begin errors++; $display("FAIL sb_lane: got %b/%h exp 0010/a5a5a5a5", cap_be, cap_wdata); end

    tick();
    set_ex(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 5'd4, 1'b1);
    run_access(2, 32'h0);
    checks++; if ({cap_be, cap_wdata, cap_addr} !== {4'b1111, 32'hCAFE_F00D, 32'h10}) begin errors++; $display("FAIL sw_lane: got %b/%h/%h exp 1111/cafef00d/00000010", cap_be, cap_wdata, cap_addr); end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL sw_bus_stable: got %b exp 1", stable); end
  endtask

  task automatic test_misalign();
    tick();
    set_ex(1'b0, 1'b0, 3'b000, 32'h0000_0011, 32'h0, 5'd6, 1'b1);
    tick();
    set_ex(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd9, 1'b1);
    @(negedge clk);
    checks++; if (MemStall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b exp 0", MemStall); end
    checks++; if (MemWriteReg !== 1'b1) begin errors++; $display("FAIL mis_prev_reg: got %b exp 1", MemWriteReg); end
    tick();
    clr_ex();
    @(negedge clk);
    checks++; if (MemMisalign !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b exp 1", MemMisalign); end
    checks++; if ({DBusReq, MemWriteReg} !== 2'b00) begin errors++; $display("FAIL mis_req_reg: got %b exp 00", {DBusReq, MemWriteReg}); end
    checks++; if (MemWriteData !== 32'h0000_0011) begin errors++; $display("FAIL mis_data_hold: got %h exp %h", MemWriteData, 32'h11); end
    tick();
    @(negedge clk);
    checks++; if ({MemMisalign, DBusReq} !== 2'b00) begin errors++; $display("FAIL mis_pulse_end: got %b exp 00", {MemMisalign, DBusReq}); end

    tick();
    set_ex(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd9, 1'b1);
    tick();
    clr_ex();
    @(negedge clk);
    checks++; if ({MemMisalign, DBusReq} !== 2'b10) begin errors++; $display("FAIL undef_f3: got %b exp 10", {MemMisalign, DBusReq}); end

    tick();
    set_ex(1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0, 5'd0, 1'b0);
    tick();
    clr_ex();
    @(negedge clk);
    checks++; if ({MemMisalign, DBusReq} !== 2'b10) begin errors++; $display("FAIL sh_misalign: got %b exp 10", {MemMisalign, DBusReq}); end
  endtask

  task automatic test_num0_and_idle_ack();
    tick();
    set_ex(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd0, 1'b1);
    run_access(1, 32'h7777_8888);
    checks++; if (MemWriteReg !== 1'b0) begin errors++; $display("FAIL lw_x0_reg: got %b exp 0", MemWriteReg); end
    checks++; if (MemWriteData !== 32'h7777_8888) begin errors++; $display("FAIL lw_x0_data: got %h exp %h", MemWriteData, 32'h7777_8888); end

    tick();
    DBusAck = 1'b1; DBusRdata = 32'h1111_1111;
    @(negedge clk);
    checks++; if ({DBusReq, MemStall} !== 2'b00) begin errors++; $display("FAIL idle_ack: got %b exp 00", {DBusReq, MemStall}); end
    tick();
    DBusAck = 1'b0;
    set_ex(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd2, 1'b1);
    tick();
    clr_ex();
    @(negedge clk);
    checks++; if ({MemWriteReg, MemWriteData} !== {1'b1, 32'h55}) begin errors++; $display("FAIL after_idle_ack: got %b/%h exp 1/00000055", MemWriteReg, MemWriteData); end
  endtask

  task automatic test_reset_busy();
    tick();
    set_ex(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd10, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    clr_ex();
    @(negedge clk);
    checks++; if (DBusReq !== 1'b1) begin errors++; $display("FAIL rstbusy_pre_req: got %b exp 1", DBusReq); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({DBusReq, MemStall, MemWriteReg, MemMisalign} !== 4'b0000) begin errors++; $display("FAIL rstbusy_flags: got %b exp 0000", {DBusReq, MemStall, MemWriteReg, MemMisalign}); end
    checks++; if ({MemWriteData, MemWriteNum} !== {32'h0, 5'd0}) begin errors++; $display("FAIL rstbusy_outs: got %h/%0d exp 0/0", MemWriteData, MemWriteNum); end

    tick();
    set_ex(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd11, 1'b1);
    run_access(2, 32'hCAFE_F00D);
    checks++; if (n_stall !== 3) begin errors++; $display("FAIL rstbusy_fresh_stall: got %0d exp 3", n_stall); end
    checks++; if ({MemWriteReg, MemWriteNum, MemWriteData} !== {1'b1, 5'd11, 32'hCAFE_F00D}) begin errors++; $display("FAIL rstbusy_fresh: got %b/%0d/%h exp 1/11/cafef00d", MemWriteReg, MemWriteNum, MemWriteData); end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int early_err;
    early_err = 0;
    tick();
    set_ex(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd12, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 5 && MemBusErr) early_err++;
      if (c == 4) begin
        checks++; if (MemStall !== 1'b0) begin errors++; $display("FAIL to_stall_limit: got %b exp 0", MemStall); end
      end
      if (c == 5) begin
        checks++; if ({MemBusErr, DBusReq, MemWriteReg} !== 3'b100) begin errors++; $display("FAIL to_abort: got %b exp 100", {MemBusErr, DBusReq, MemWriteReg}); end
      end
      tick();
      if (c == 4) clr_ex();
    end
    checks++; if (early_err !== 0) begin errors++; $display("FAIL to_early: got %0d exp 0", early_err); end
    tick();
    set_ex(1'b1, 1'b0, 3'b010, 32'h0000_0504, 32'h0, 5'd12, 1'b1);
    run_access(3, 32'h1111_2222);
    checks++; if ({MemBusErr, MemWriteReg, MemWriteData} !== {1'b0, 1'b1, 32'h1111_2222}) begin errors++; $display("FAIL to_ack_wins: got %b/%b/%h exp 0/1/11112222", MemBusErr, MemWriteReg, MemWriteData); end
  endtask
`else
  task automatic test_long_wait();
    tick();
    set_ex(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd13, 1'b1);
    run_access(20, 32'h3333_4444);
    checks++; if (n_stall !== 21) begin errors++; $display("FAIL long_stall: got %0d exp 21", n_stall); end
    checks++; if ({MemBusErr, MemWriteData} !== {1'b0, 32'h3333_4444}) begin errors++; $display("FAIL long_result: got %b/%h exp 0/33334444", MemBusErr, MemWriteData); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    ExValid = 1'b0; ExMemRead = 1'b0; ExMemWrite = 1'b0; ExFunct3 = 3'b000;
    ExAluResult = 32'h0; ExStoreData = 32'h0; ExWriteNum = 5'd0; ExWriteReg = 1'b0;
    DBusAck = 1'b0; DBusRdata = 32'h0;
    test_reset();
    test_nonmem();
    test_loads();
    test_stores();
    test_misalign();
    test_num0_and_idle_ack();
    test_reset_busy();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
